// File: rtl/i2s_receiver_if.sv
// -----------------------------------------------------------------------------
// i2s_receiver_if
//
// Purpose: bundles the codec-side serial lines and the parallel sample outputs
// of the I2S receiver so the block and its user connect through one port.
//
// Signals:
//   AUD_BCLK        codec bit clock (asynchronous to CLOCK_50)
//   AUD_ADCLRCK     codec word clock, 0 = left, 1 = right (asynchronous)
//   AUD_ADCDAT      codec serial data (asynchronous)
//   leftSampleOut   last complete left sample, two's complement
//   rightSampleOut  last complete right sample, two's complement
//   sampleValid     one-cycle strobe when both samples update together
//   frameError      one-cycle strobe when a channel word is truncated
//
// Modports:
//   master  codec / sample consumer side (drives the serial lines)
//   slave   the receiver (drives the sample outputs and strobes)
// -----------------------------------------------------------------------------
interface i2s_receiver_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic                    AUD_BCLK;
    logic                    AUD_ADCLRCK;
    logic                    AUD_ADCDAT;
    logic [SAMPLE_WIDTH-1:0] leftSampleOut;
    logic [SAMPLE_WIDTH-1:0] rightSampleOut;
    logic                    sampleValid;
    logic                    frameError;

    modport master (
        output AUD_BCLK,
        output AUD_ADCLRCK,
        output AUD_ADCDAT,
        input  leftSampleOut,
        input  rightSampleOut,
        input  sampleValid,
        input  frameError
    );

    modport slave (
        input  AUD_BCLK,
        input  AUD_ADCLRCK,
        input  AUD_ADCDAT,
        output leftSampleOut,
        output rightSampleOut,
        output sampleValid,
        output frameError
    );
endinterface

// File: rtl/i2s_receiver.sv
// -----------------------------------------------------------------------------
// i2s_receiver
//
// Purpose: deserialises the codec's standard-I2S ADC stream into parallel
// signed left/right sample pairs for the echo/delay stage. The codec clocks
// are oversampled and edge-detected in the CLOCK_50 domain; a one-cycle
// strobe marks each new stereo pair.
//
// Parameters:
//   SAMPLE_WIDTH  bits captured per channel, MSB first (extra slot bits ignored)
//   SYNC_STAGES   synchroniser depth on all three codec inputs (minimum 2)
//
// Ports:
//   CLOCK_50  in   system clock, all registers use its rising edge
//   Reset     in   synchronous, active-high reset
//   bus       slave modport of i2s_receiver_if (codec lines in, samples out)
// -----------------------------------------------------------------------------
module i2s_receiver #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          CLOCK_50,
    input  logic          Reset,
    i2s_receiver_if.slave bus
);

    localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Synchronisers: all three lines share the same depth so they stay aligned.
    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrck_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_bclk_prev;
    logic                   r_lrck_prev;

    logic w_bclk;
    logic w_lrck;
    logic w_data;
    logic w_bclk_rise;
    logic w_lr_edge;

    // Capture state. The shift register holds only the bits already captured;
    // the final bit of a word is taken straight from the data line on commit.
    state_t                  r_state;
    logic                    r_chan;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [SAMPLE_WIDTH-2:0] r_shift_reg;
    logic [SAMPLE_WIDTH-1:0] r_left_pending;
    logic                    r_left_ok;
    logic [SAMPLE_WIDTH-1:0] r_left_out;
    logic [SAMPLE_WIDTH-1:0] r_right_out;
    logic                    r_valid;
    logic                    r_error;

    state_t                  w_state_next;
    logic                    w_chan_next;
    logic [CNT_W-1:0]        w_bit_cnt_next;
    logic [SAMPLE_WIDTH-2:0] w_shift_next;
    logic [SAMPLE_WIDTH-1:0] w_left_pending_next;
    logic                    w_left_ok_next;
    logic [SAMPLE_WIDTH-1:0] w_left_out_next;
    logic [SAMPLE_WIDTH-1:0] w_right_out_next;
    logic                    w_valid_next;
    logic                    w_error_next;
    logic [SAMPLE_WIDTH-1:0] w_word;

    // -------------------------------------------------------------------------
    // Input synchronisation and edge detection
    // -------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others, exactly like hardware.
        if (Reset) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_data_sync <= '0;
            r_bclk_prev <= 1'b0;
            r_lrck_prev <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], bus.AUD_BCLK};
            r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], bus.AUD_ADCLRCK};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.AUD_ADCDAT};
            r_bclk_prev <= w_bclk;
            r_lrck_prev <= w_lrck;
        end
    end

    assign w_bclk      = r_bclk_sync[SYNC_STAGES-1];
    assign w_lrck      = r_lrck_sync[SYNC_STAGES-1];
    assign w_data      = r_data_sync[SYNC_STAGES-1];
    assign w_bclk_rise = w_bclk & ~r_bclk_prev;
    assign w_lr_edge   = w_lrck ^ r_lrck_prev;

    // -------------------------------------------------------------------------
    // Framing state machine: next-state and commit logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        w_state_next        = r_state;
        w_chan_next         = r_chan;
        w_bit_cnt_next      = r_bit_cnt;
        w_shift_next        = r_shift_reg;
        w_left_pending_next = r_left_pending;
        w_left_ok_next      = r_left_ok;
        w_left_out_next     = r_left_out;
        w_right_out_next    = r_right_out;
        w_valid_next        = 1'b0;
        w_error_next        = 1'b0;
        w_word              = {r_shift_reg, w_data};

        if (w_lr_edge) begin
            // A word still being collected is cut short: drop it and make sure
            // the next right word cannot pair with a stale left word.
            if (r_state == ST_DELAY || r_state == ST_SHIFT) begin
                w_error_next   = 1'b1;
                w_left_ok_next = 1'b0;
            end
            w_chan_next    = w_lrck;
            w_bit_cnt_next = '0;
            // An LRCK transition coinciding with a BCLK rise: the edge goes
            // first, so that rise is already the one-bit I2S delay.
            w_state_next   = w_bclk_rise ? ST_SHIFT : ST_DELAY;
        end else if (w_bclk_rise) begin
            case (r_state)
                ST_DELAY: begin
                    w_state_next   = ST_SHIFT;
                    w_bit_cnt_next = '0;
                end
                ST_SHIFT: begin
                    w_shift_next   = w_word[SAMPLE_WIDTH-2:0];
                    w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == CNT_W'(SAMPLE_WIDTH - 1)) begin
                        w_state_next = ST_DONE;
                        if (!r_chan) begin
                            w_left_pending_next = w_word;
                            w_left_ok_next      = 1'b1;
                        end else if (r_left_ok) begin
                            w_left_out_next  = r_left_pending;
                            w_right_out_next = w_word;
                            w_valid_next     = 1'b1;
                            w_left_ok_next   = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Framing state machine: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        // NOTE: the data-path registers are reset too, so the outputs read 0
        // after reset and no stale word can leak into the first pair.
        if (Reset) begin
            r_state        <= ST_IDLE;
            r_chan         <= 1'b0;
            r_bit_cnt      <= '0;
            r_shift_reg    <= '0;
            r_left_pending <= '0;
            r_left_ok      <= 1'b0;
            r_left_out     <= '0;
            r_right_out    <= '0;
            r_valid        <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_chan         <= w_chan_next;
            r_bit_cnt      <= w_bit_cnt_next;
            r_shift_reg    <= w_shift_next;
            r_left_pending <= w_left_pending_next;
            r_left_ok      <= w_left_ok_next;
            r_left_out     <= w_left_out_next;
            r_right_out    <= w_right_out_next;
            r_valid        <= w_valid_next;
            r_error        <= w_error_next;
        end
    end

    assign bus.leftSampleOut  = r_left_out;
    assign bus.rightSampleOut = r_right_out;
    assign bus.sampleValid    = r_valid;
    assign bus.frameError     = r_error;

endmodule

// File: tb/tb_i2s_receiver.sv
// -----------------------------------------------------------------------------
// tb_i2s_receiver
//
// Self-checking bench for i2s_receiver. A codec driver plays I2S slots one BCLK
// period at a time (BCLK = CLOCK_50/6). A reference model tracks each slot by
// position (rise 1 after an LRCK change is the delay bit, rises 2..W+1 carry
// the word) and predicts every stereo pair, its arrival cycle and the number
// of truncation errors. A table of frames with hand-derived expectations, a
// few hand-written reset sequences and a randomised run are applied.
// -----------------------------------------------------------------------------
module tb_i2s_receiver;

    localparam int W    = 16;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    i2s_receiver_if #(.SAMPLE_WIDTH(W)) bus ();

    i2s_receiver #(
        .SAMPLE_WIDTH(W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLOCK_50(clk),
        .Reset   (rst),
        .bus     (bus)
    );

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           cyc;
    } pair_t;

    pair_t        exp_q[$];
    bit           m_aligned;
    bit           m_chan;
    bit           m_prev_lr;
    bit           m_lok;
    int           m_run;
    logic [W-1:0] m_word;
    logic [W-1:0] m_lpend;
    logic [W-1:0] m_out_l;
    logic [W-1:0] m_out_r;
    int           m_exp_err   = 0;
    int           m_exp_valid = 0;

    // Monitor state
    int    n_cyc        = 0;
    int    n_valid_seen = 0;
    int    n_err_seen   = 0;
    pair_t mon_p;

    task automatic model_reset();
        m_aligned = 1'b0;
        m_chan    = 1'b0;
        m_prev_lr = 1'b0;
        m_lok     = 1'b0;
        m_run     = 0;
        m_word    = '0;
        m_lpend   = '0;
        m_out_l   = '0;
        m_out_r   = '0;
        exp_q.delete();
    endtask

    // One BCLK period: LRCK/DATA change with BCLK low, then BCLK rises.
    task automatic drive_period(input bit lr, input bit d);
        bus.AUD_BCLK    = 1'b0;
        bus.AUD_ADCLRCK = lr;
        bus.AUD_ADCDAT  = d;
        if (lr != m_prev_lr) begin
            if (m_aligned && m_run <= W) begin
                m_exp_err++;
                m_lok = 1'b0;
            end
            m_aligned = 1'b1;
            m_run     = 0;
            m_chan    = lr;
            m_prev_lr = lr;
        end
        repeat (3) tick();
        bus.AUD_BCLK = 1'b1;
        if (m_aligned && m_run <= W) begin
            m_run++;
            if (m_run >= 2) m_word = {m_word[W-2:0], d};
            if (m_run == W + 1) begin
                if (!m_chan) begin
                    m_lpend = m_word;
                    m_lok   = 1'b1;
                end else if (m_lok) begin
                    exp_q.push_back('{m_lpend, m_word, n_cyc});
                    m_out_l = m_lpend;
                    m_out_r = m_word;
                    m_exp_valid++;
                    m_lok = 1'b0;
                end
            end
        end
        repeat (3) tick();
    endtask

    task automatic do_reset(input int ncyc, input bit toggle);
        bit keep_lr;
        keep_lr = bus.AUD_ADCLRCK;
        bus.AUD_BCLK = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < ncyc; i++) begin
            if (toggle) begin
                bus.AUD_BCLK    = 1'($urandom);
                bus.AUD_ADCLRCK = 1'($urandom);
                bus.AUD_ADCDAT  = 1'($urandom);
            end
            tick();
            check("rst_left",  32'(bus.leftSampleOut),  32'h0);
            check("rst_right", 32'(bus.rightSampleOut), 32'h0);
            check("rst_valid", 32'(bus.sampleValid),    32'h0);
            check("rst_error", 32'(bus.frameError),     32'h0);
        end
        bus.AUD_BCLK    = 1'b0;
        bus.AUD_ADCLRCK = keep_lr;
        bus.AUD_ADCDAT  = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    // A slot is one delay period then nbits data bits, MSB first. rst_at >= 1
    // pulses Reset before that period (same LRCK level kept across it).
    task automatic send_slot(input bit lr, input int nbits, input logic [31:0] word, input int rst_at);
        for (int p = 0; p <= nbits; p++) begin
            if (p == rst_at) do_reset(1 + (p % 2), 1'b0);
            if (p == 0) drive_period(lr, 1'($urandom));
            else        drive_period(lr, word[nbits-p]);
        end
    endtask

    // -------------------------------------------------------------------------
    // Output monitor (samples on the falling edge)
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        n_cyc = n_cyc + 1;
        if (bus.sampleValid === 1'b1 || bus.frameError === 1'b1)
            check("pulse_exclusive", 32'(bus.sampleValid & bus.frameError), 32'h0);
        if (bus.sampleValid === 1'b1) begin
            n_valid_seen = n_valid_seen + 1;
            if (exp_q.size() > 0) begin
                mon_p = exp_q.pop_front();
                check("pair_left",     32'(bus.leftSampleOut),  32'(mon_p.l));
                check("pair_right",    32'(bus.rightSampleOut), 32'(mon_p.r));
                check("valid_latency", 32'(n_cyc - mon_p.cyc),  32'(SYNC + 2));
            end
        end
        if (bus.frameError === 1'b1) n_err_seen = n_err_seen + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, n_cyc=%0d", n_cyc);
        $fatal(1);
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    typedef struct {
        int           nl;
        logic [31:0]  wl;
        int           nr;
        logic [31:0]  wr;
        int           exp_v;
        int           exp_e;
        logic [W-1:0] exp_l;
        logic [W-1:0] exp_r;
    } row_t;

    row_t rows[8];
    int   v0;
    int   e0;

    task automatic check_deltas(input string tag, input int ev, input int ee,
                                input logic [W-1:0] el, input logic [W-1:0] er);
        check({tag, "_valid"}, 32'(n_valid_seen - v0), 32'(ev));
        check({tag, "_error"}, 32'(n_err_seen - e0),   32'(ee));
        check({tag, "_left"},  32'(bus.leftSampleOut),  32'(el));
        check({tag, "_right"}, 32'(bus.rightSampleOut), 32'(er));
    endtask

    initial begin
        // Slot lengths are data bits; each slot adds one delay period.
        rows[0] = '{16, 32'h0000_1234, 16, 32'h0000_ABCD, 0, 0, 16'h0000, 16'h0000}; // left lost before alignment
        rows[1] = '{16, 32'h0000_1234, 16, 32'h0000_ABCD, 1, 0, 16'h1234, 16'hABCD};
        rows[2] = '{32, 32'h8000_1357, 32, 32'hFFFF_2468, 1, 0, 16'h8000, 16'hFFFF}; // trailing bits ignored
        rows[3] = '{10, 32'h0000_02AB, 16, 32'h0000_5555, 0, 1, 16'h8000, 16'hFFFF}; // left truncated
        rows[4] = '{16, 32'h0000_7FFF, 16, 32'h0000_0001, 1, 0, 16'h7FFF, 16'h0001};
        rows[5] = '{16, 32'h0000_1111, 15, 32'h0000_2222, 0, 0, 16'h7FFF, 16'h0001}; // right one bit short
        rows[6] = '{16, 32'h0000_A5A5, 16, 32'h0000_5A5A, 1, 1, 16'hA5A5, 16'h5A5A}; // short right flagged here
        rows[7] = '{17, 32'h0001_0F0F, 16, 32'h0000_C3C3, 1, 0, 16'h8787, 16'hC3C3};

        bus.AUD_BCLK    = 1'b0;
        bus.AUD_ADCLRCK = 1'b0;
        bus.AUD_ADCDAT  = 1'b0;
        model_reset();

        // Reset held 5 cycles with the codec lines toggling.
        do_reset(5, 1'b1);

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            v0 = n_valid_seen;
            e0 = n_err_seen;
            send_slot(1'b0, rows[i].nl, rows[i].wl, -1);
            send_slot(1'b1, rows[i].nr, rows[i].wr, -1);
            repeat (4) tick();
            check_deltas($sformatf("row%0d", i), rows[i].exp_v, rows[i].exp_e,
                         rows[i].exp_l, rows[i].exp_r);
        end

        // Reset released with LRCK=1 in the middle of a right slot: the rest
        // of that slot is collected, then cut short by the next left edge.
        v0 = n_valid_seen;
        e0 = n_err_seen;
        send_slot(1'b0, 16, 32'h0000_0F0F, -1);
        send_slot(1'b1, 16, 32'h0000_F0F0, 8);
        send_slot(1'b0, 16, 32'h0000_1357, -1);
        send_slot(1'b1, 16, 32'h0000_2468, -1);
        repeat (4) tick();
        check_deltas("rst_mid_right", 1, 1, 16'h1357, 16'h2468);

        // Single-cycle Reset pulse mid-SHIFT of a right word.
        v0 = n_valid_seen;
        e0 = n_err_seen;
        send_slot(1'b0, 16, 32'h0000_4444, -1);
        send_slot(1'b1, 16, 32'h0000_8888, 10);
        send_slot(1'b0, 16, 32'h0000_6666, -1);
        send_slot(1'b1, 16, 32'h0000_9999, -1);
        repeat (4) tick();
        check_deltas("rst_pulse", 1, 1, 16'h6666, 16'h9999);

        // Randomised frames: mostly valid slot lengths, some truncated,
        // some long, occasional mid-slot reset.
        for (int f = 0; f < 30; f++) begin
            int          nb[2];
            int          ra[2];
            logic [31:0] wd[2];
            for (int c = 0; c < 2; c++) begin
                int sel;
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      nb[c] = int'($urandom_range(0, 15));
                else if (sel == 1) nb[c] = 32;
                else               nb[c] = 16 + int'($urandom_range(0, 3));
                wd[c] = $urandom;
                ra[c] = -1;
                if (nb[c] > 0 && $urandom_range(0, 9) == 0)
                    ra[c] = int'($urandom_range(1, nb[c]));
            end
            send_slot(1'b0, nb[0], wd[0], ra[0]);
            send_slot(1'b1, nb[1], wd[1], ra[1]);
        end
        repeat (8) tick();

        check("total_valid",   32'(n_valid_seen),   32'(m_exp_valid));
        check("total_error",   32'(n_err_seen),     32'(m_exp_err));
        check("final_left",    32'(bus.leftSampleOut),  32'(m_out_l));
        check("final_right",   32'(bus.rightSampleOut), 32'(m_out_r));
        check("queue_drained", 32'(exp_q.size()),   32'h0);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

Deserialises the audio codec's I2S ADC stream into parallel signed 16-bit left/right sample pairs for the effects chain. It sits directly upstream of the echo/delay stage and drives its `leftSampleIn`/`rightSampleIn` inputs. The codec-side clocks are oversampled and edge-detected in the 50 MHz domain. A one-cycle strobe marks each new stereo pair.

## Interface
- `SAMPLE_WIDTH`, 16: bits captured per channel, MSB first. Codec bits beyond this count are ignored.
- `SYNC_STAGES`, 2: flip-flop synchroniser depth on `AUD_BCLK`, `AUD_ADCLRCK` and `AUD_ADCDAT`. Minimum 2.

- `CLOCK_50`  in  1  system clock, 50 MHz. Every register in the block uses its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `AUD_BCLK`  in  1  codec bit clock, asynchronous to `CLOCK_50`. Maximum frequency is CLOCK_50/4.
- `AUD_ADCLRCK`  in  1  codec word clock, asynchronous. 0 = left channel, 1 = right channel.
- `AUD_ADCDAT`  in  1  codec serial data, asynchronous.
- `leftSampleOut`  out  SAMPLE_WIDTH  last complete left sample, two's complement.
- `rightSampleOut`  out  SAMPLE_WIDTH  last complete right sample, two's complement.
- `sampleValid`  out  1  one-cycle pulse when both outputs update together.
- `frameError`  out  1  one-cycle pulse when a channel word is truncated.

## Operation
- Synchronisation:
  - All three codec inputs pass through `SYNC_STAGES` flops, so they stay mutually aligned.
  - `bclkRise` = synchronised BCLK was 0 last cycle and is 1 now.
  - `lrEdge` = synchronised LRCK differs from its value one cycle ago.
- Only LRCK and DATA values present on a `bclkRise` cycle are acted on. The only exception is `lrEdge`, which is checked every cycle.
- Format is standard I2S: the MSB is on the second BCLK rising edge after an LRCK transition, i.e. there is a one-bit delay.
- State machine:
  - IDLE: entered on reset. Ignores all data. Goes to DELAY on the first `lrEdge`, latching `chan` = new LRCK value. This realigns after reset or start mid-frame.
  - DELAY: on the next `bclkRise`, goes to SHIFT with `bitCnt` = 0. No data is captured.
  - SHIFT: on each `bclkRise`, `shiftReg` = {shiftReg[SAMPLE_WIDTH-2:0], data} and `bitCnt` increments. When the SAMPLE_WIDTH-th bit is captured, the machine commits (see below) and goes to DONE.
  - DONE: ignores any remaining bits of the slot. On `lrEdge`, goes to DELAY with the new `chan`.
- Commit, same cycle as the final shift:
  - Left channel: the word goes to the internal `leftPending` register and `leftOk` is set to 1.
  - Right channel with `leftOk` = 1: `leftSampleOut` ← `leftPending` and `rightSampleOut` ← the word. `sampleValid` pulses and `leftOk` is cleared.
  - Right channel with `leftOk` = 0: the word is discarded and there is no pulse. A pair is never emitted without a fresh left word.
- Early LRCK edge (`lrEdge` while in DELAY or SHIFT):
  - The partial word is discarded, `frameError` pulses for one cycle and `leftOk` is cleared.
  - The machine goes to DELAY with the new `chan`.
- No arithmetic is performed. Bits are copied verbatim, so sign is preserved.

## Timing
- Reset values:
  - `leftSampleOut` = 0, `rightSampleOut` = 0, `sampleValid` = 0, `frameError` = 0.
  - state = IDLE, `leftOk` = 0, `shiftReg` = 0, `bitCnt` = 0.
  - Synchroniser flops = 0.
- Reset is synchronous and dominates all other events in the same cycle. Reset mid-word abandons the word, and the first pair after reset needs a full left and right slot following an LRCK edge.
- Outputs are registered:
  - The sample outputs and `sampleValid` update on the `CLOCK_50` edge after the cycle in which the right LSB's `bclkRise` is detected.
  - That is SYNC_STAGES+2 `CLOCK_50` cycles after the physical BCLK rising edge.
  - The outputs hold their value until the next commit.
- `sampleValid` is high for exactly one cycle per stereo frame. `sampleValid` and `frameError` never assert in the same cycle.
- A simultaneous `lrEdge` and `bclkRise` is an LRCK transition. The edge is processed first, so the bit on that `bclkRise` counts as the DELAY bit.

## Test plan
- Reset hold of 5 cycles with the codec toggling -> all outputs 0, no pulses during reset.
- Two I2S frames with 16-bit slots, left = 0x1234, right = 0xABCD -> after the second frame, `leftSampleOut` = 0x1234 and `rightSampleOut` = 0xABCD. `sampleValid` pulses exactly once per complete frame, and the first pulse comes SYNC_STAGES+2 cycles after the right LSB's BCLK rising edge.
- 32-bit slots, left = 0x8000_xxxx, right = 0xFFFF_xxxx -> outputs are 0x8000 and 0xFFFF. The trailing 16 bits of each slot are ignored, and there is one pulse per frame.
- Left slot truncated by an LRCK edge after 10 bits -> `frameError` pulses once. The following right word 0x5555 produces no `sampleValid`, and the outputs keep their previous values.
- Reset deasserted while LRCK = 1 in the middle of a right slot -> that partial right slot is ignored. The first `sampleValid` comes after the next complete left and right slots.
- `Reset` pulsed mid-SHIFT of a right word -> outputs go to 0 on the next cycle, no `sampleValid` is emitted for that frame, and normal output resumes one full frame later.
